dot_matrix_scanner: RTL and testbench
=====================================

DOT_MATRIX_SCANNER -- requirements
Module: dot_matrix_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 8, number of matrix rows (2..16).
REQ-002 SHALL have parameter COLS, default 16, number of matrix columns (1..32).
REQ-003 SHALL have parameter DWELL, default 1, div_clk_10k ticks each row is driven (1..255).
REQ-004 SHALL have port div_clk_10k  in  1  scan clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_en  in  1  one-cycle pixel write strobe into back buffer.
REQ-007 SHALL have port wr_row  in  clog2(ROWS)  target row of write.
REQ-008 SHALL have port wr_col  in  clog2(COLS)  target column of write.
REQ-009 SHALL have port wr_op  in  2  00 write wr_data, 01 set, 10 clear, 11 toggle.
REQ-010 SHALL have port wr_data  in  1  pixel value for wr_op=00.
REQ-011 SHALL have port clr_all  in  1  clear entire back buffer.
REQ-012 SHALL have port commit  in  1  request back-to-front copy at next frame boundary.
REQ-013 SHALL have port commit_pending  out  1  copy requested, not yet done.
REQ-014 SHALL have port frame_done  out  1  one-cycle pulse per completed frame.
REQ-015 SHALL have port dotR  out  ROWS  row select, active-low one-hot.
REQ-016 SHALL have port dotC  out  COLS  column data, active-high, registered.

Function
REQ-017 SHALL hold two ROWS*COLS bit buffers: back (written) and front (displayed).
REQ-018 SHALL scan with row counter r (0..ROWS-1) and dwell counter d (0..DWELL-1); d wraps then r increments; r wraps ROWS-1 -> 0.
REQ-019 SHALL, while row r is driven, output dotR bit (ROWS-1-r) = 0, all others 1, and dotC = front[r*COLS +: COLS].
REQ-020 SHALL register outputs; first edge after reset release drives row 0, dwell 0.
REQ-021 SHALL apply wr_en on the same edge to back[wr_row*COLS+wr_col] per wr_op; rows >= ROWS or cols >= COLS ignored.
REQ-022 SHALL give clr_all priority over a simultaneous wr_en (back becomes all zero, write dropped).
REQ-023 SHALL set commit_pending on the edge sampling commit=1; repeated commits while pending are merged.
REQ-024 SHALL copy back to front on the edge driving the last dwell tick of row ROWS-1 when commit_pending is 1, and clear commit_pending on that edge; the next edge shows new row 0.
REQ-025 SHALL copy back as it stood before that edge; a write on the copy edge lands in back only.
REQ-026 SHALL set commit_pending (not copy) when commit arrives on the copy edge itself; copy occurs at the following frame boundary.
REQ-027 SHALL assert frame_done for exactly one cycle on the edge driving the last dwell tick of row ROWS-1.
REQ-028 SHALL never change front except at a frame boundary (no tearing).

Reset
REQ-029 SHALL on reset=0 immediately force dotR all ones, dotC 0, frame_done 0, commit_pending 0, r=0, d=0, both buffers zero.
REQ-030 SHALL abort scan on reset mid-frame; restart from row 0 per REQ-020; pending commit discarded.

Configuration
REQ-031 SHALL, with DOTSCAN_BLANK_EN defined, insert one blank tick (dotR all ones, dotC 0) after each row's last dwell tick, row period DWELL+1, frame_done/copy on the blank tick after row ROWS-1; without it, no blank ticks, row period DWELL.

Verification (ROWS=8, COLS=16, DWELL=1, macro undefined unless stated)
REQ-032 SHALL check reset release: edges 0..7 give dotR 0x7F,0xBF,...,0xFE, dotC 0x0000; frame_done pulses at edge 7, 15.
REQ-033 SHALL check write set row2 col0, commit mid-frame: dotC stays 0 until next frame; row2 then shows 0x0001; commit_pending clears at copy edge.
REQ-034 SHALL check toggle row5 col15 twice plus set col3, commit: row5 shows 0x0008.
REQ-035 SHALL check clr_all with simultaneous wr_en row0 col0 set, commit: row0 shows 0x0000.
REQ-036 SHALL check reset asserted during row 4 with commit pending: outputs blank at once, after release row 0 shows 0x0000, commit_pending 0.
REQ-037 SHALL check DOTSCAN_BLANK_EN, DWELL=2: pattern row0,row0,blank,row1,...; frame_done every 24 edges.

Source files
------------

// File: rtl/dot_matrix_scanner.sv
// dot_matrix_scanner: double-buffered LED dot-matrix row scanner.
// Pixel writes go to a back buffer. A commit copies it to the displayed
// front buffer at the next frame boundary, so the image never tears.
// Optional build macro: DOTSCAN_BLANK_EN inserts one blank tick after each
// row (row period DWELL+1) to suppress ghosting between rows.
module dot_matrix_scanner #(
    parameter int ROWS  = 8,
    parameter int COLS  = 16,
    parameter int DWELL = 1,
    localparam int RW   = $clog2(ROWS),
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic            div_clk_10k,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [CW-1:0]   wr_col,
    input  logic [1:0]      wr_op,
    input  logic            wr_data,
    input  logic            clr_all,
    input  logic            commit,
    output logic            commit_pending,
    output logic            frame_done,
    output logic [ROWS-1:0] dotR,
    output logic [COLS-1:0] dotC
);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DWELL - 1);

    // run_q is low until the first edge after reset, which must show row 0
    // dwell 0 rather than advancing past it.
    logic                      run_q;
    logic [RW-1:0]             r_q, r_d;
    logic [DW-1:0]             d_q, d_d;
    logic                      blank_d;
    logic                      bnd;
    logic [ROWS-1:0][COLS-1:0] back_q, back_d;
    logic [ROWS-1:0][COLS-1:0] front_q, front_d;
    logic                      pend_q, pend_d;
    logic [ROWS-1:0]           dotR_q, dotR_d;
    logic [COLS-1:0]           dotC_q, dotC_d;
    logic                      fd_q;
`ifdef DOTSCAN_BLANK_EN
    logic                      blank_q;
`endif

    // Next scan position, plus the frame-boundary flag for the tick it starts.
    always_comb begin
        r_d     = r_q;
        d_d     = d_q;
        blank_d = 1'b0;
        if (!run_q) begin
            r_d = '0;
            d_d = '0;
        end else begin
`ifdef DOTSCAN_BLANK_EN
            if (blank_q) begin
                d_d = '0;
                r_d = (r_q == R_LAST) ? '0 : r_q + 1'b1;
            end else if (d_q == D_LAST) begin
                blank_d = 1'b1;
            end else begin
                d_d = d_q + 1'b1;
            end
`else
            if (d_q == D_LAST) begin
                d_d = '0;
                r_d = (r_q == R_LAST) ? '0 : r_q + 1'b1;
            end else begin
                d_d = d_q + 1'b1;
            end
`endif
        end
`ifdef DOTSCAN_BLANK_EN
        bnd = blank_d && (r_d == R_LAST);
`else
        bnd = run_q && (r_d == R_LAST) && (d_d == D_LAST);
`endif
    end

    // Row/column drive for the tick being entered; dotC reads the front
    // buffer as it stands before any copy on this same edge.
    always_comb begin
        for (int i = 0; i < ROWS; i++)
            dotR_d[i] = blank_d || (i != (ROWS - 1 - int'(r_d)));
        dotC_d = blank_d ? '0 : front_q[r_d];
    end

    // Back-buffer edits; clr_all wins over a coincident pixel write.
    always_comb begin
        back_d = back_q;
        if (clr_all) begin
            back_d = '0;
        end else if (wr_en && int'(wr_row) < ROWS && int'(wr_col) < COLS) begin
            case (wr_op)
                2'b00:   back_d[wr_row][wr_col] = wr_data;
                2'b01:   back_d[wr_row][wr_col] = 1'b1;
                2'b10:   back_d[wr_row][wr_col] = 1'b0;
                default: back_d[wr_row][wr_col] = ~back_q[wr_row][wr_col];
            endcase
        end
    end

    // Frame-boundary copy and commit bookkeeping; a commit landing on the
    // copy edge re-arms for the next boundary instead of being lost.
    always_comb begin
        front_d = front_q;
        pend_d  = pend_q;
        if (bnd && pend_q) begin
            front_d = back_q;
            pend_d  = 1'b0;
        end
        if (commit) pend_d = 1'b1;
    end

    // State and registered outputs; reset blanks the display at once.
    always_ff @(posedge div_clk_10k or negedge reset) begin
        if (!reset) begin
            run_q   <= 1'b0;
            r_q     <= '0;
            d_q     <= '0;
            back_q  <= '0;
            front_q <= '0;
            pend_q  <= 1'b0;
            fd_q    <= 1'b0;
            dotR_q  <= '1;
            dotC_q  <= '0;
        end else begin
            run_q   <= 1'b1;
            r_q     <= r_d;
            d_q     <= d_d;
            back_q  <= back_d;
            front_q <= front_d;
            pend_q  <= pend_d;
            fd_q    <= bnd;
            dotR_q  <= dotR_d;
            dotC_q  <= dotC_d;
        end
    end

`ifdef DOTSCAN_BLANK_EN
    // Blank-tick phase flag.
    always_ff @(posedge div_clk_10k or negedge reset) begin
        if (!reset) blank_q <= 1'b0;
        else        blank_q <= blank_d;
    end
`endif

    assign commit_pending = pend_q;
    assign frame_done     = fd_q;
    assign dotR           = dotR_q;
    assign dotC           = dotC_q;
endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Bench for dot_matrix_scanner (ROWS=8, COLS=16). With DOTSCAN_BLANK_EN
// defined it runs DWELL=2 with blank ticks, otherwise DWELL=1.
module tb_dot_matrix_scanner;
    localparam int ROWS = 8;
    localparam int COLS = 16;
`ifdef DOTSCAN_BLANK_EN
    localparam int DWELL = 2;
    localparam int BL    = 1;
`else
    localparam int DWELL = 1;
    localparam int BL    = 0;
`endif
    localparam int P  = DWELL + BL;   // ticks per row
    localparam int FR = P * ROWS;     // ticks per frame

    logic            div_clk_10k = 1'b0;
    logic            reset = 1'b0;
    logic            wr_en = 1'b0;
    logic [2:0]      wr_row = '0;
    logic [3:0]      wr_col = '0;
    logic [1:0]      wr_op = '0;
    logic            wr_data = 1'b0;
    logic            clr_all = 1'b0;
    logic            commit = 1'b0;
    logic            commit_pending;
    logic            frame_done;
    logic [ROWS-1:0] dotR;
    logic [COLS-1:0] dotC;

    dot_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL)) dut (
        .div_clk_10k    (div_clk_10k),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_row         (wr_row),
        .wr_col         (wr_col),
        .wr_op          (wr_op),
        .wr_data        (wr_data),
        .clr_all        (clr_all),
        .commit         (commit),
        .commit_pending (commit_pending),
        .frame_done     (frame_done),
        .dotR           (dotR),
        .dotC           (dotC)
    );

    always #5 div_clk_10k = ~div_clk_10k;

    typedef struct packed {
        logic [ROWS-1:0] r;
        logic [COLS-1:0] c;
        logic            fd;
        logic            pd;
    } exp_t;

    exp_t            sb[$];
    logic [COLS-1:0] m_back[ROWS];
    logic [COLS-1:0] m_front[ROWS];
    logic            m_pend;
    int              t;
    int              n_chk = 0;
    int              n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ROWS; i++) begin
            m_back[i]  = '0;
            m_front[i] = '0;
        end
        m_pend = 1'b0;
        t = 0;
        sb.delete();
    endtask

    // Drive one tick of stimulus, predict the outputs of the coming edge,
    // then compare after the edge.
    task automatic step(input logic we, input int row, input int col, input logic [1:0] op,
                        input logic dat, input logic clr, input logic cm);
        exp_t e, g;
        int   rr;
        logic bl;
        wr_en = we; wr_row = 3'(row); wr_col = 4'(col); wr_op = op;
        wr_data = dat; clr_all = clr; commit = cm;
        rr   = (t / P) % ROWS;
        bl   = (t % P) == DWELL;
        e.r  = '1;
        if (!bl) e.r[ROWS-1-rr] = 1'b0;
        e.c  = bl ? '0 : m_front[rr];
        e.fd = (t % FR) == FR - 1;
        if (e.fd && m_pend) begin
            for (int i = 0; i < ROWS; i++) m_front[i] = m_back[i];
            m_pend = 1'b0;
        end
        if (cm) m_pend = 1'b1;
        if (clr) begin
            for (int i = 0; i < ROWS; i++) m_back[i] = '0;
        end else if (we) begin
            case (op)
                2'b00:   m_back[row][col] = dat;
                2'b01:   m_back[row][col] = 1'b1;
                2'b10:   m_back[row][col] = 1'b0;
                default: m_back[row][col] = ~m_back[row][col];
            endcase
        end
        e.pd = m_pend;
        sb.push_back(e);
        @(posedge div_clk_10k); #1;
        g = sb.pop_front();
        chk($sformatf("t%0d dotR", t), 32'(dotR), 32'(g.r));
        chk($sformatf("t%0d dotC", t), 32'(dotC), 32'(g.c));
        chk($sformatf("t%0d frame_done", t), 32'(frame_done), 32'(g.fd));
        chk($sformatf("t%0d commit_pending", t), 32'(commit_pending), 32'(g.pd));
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    // Idle until the next step will drive frame tick k.
    task automatic wait_tick(input int k);
        for (int i = 0; i < FR && (t % FR) != k; i++) idle(1);
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, " dotR"}, 32'(dotR), 32'(ROWS'('1)));
        chk({tag, " dotC"}, 32'(dotC), 32'h0);
        chk({tag, " frame_done"}, 32'(frame_done), 32'h0);
        chk({tag, " commit_pending"}, 32'(commit_pending), 32'h0);
    endtask

    initial begin
        model_reset();
        @(posedge div_clk_10k); #1;
        chk_blank("rst");
        @(posedge div_clk_10k); #1;
        reset = 1'b1;

        // Plain scan of an empty display.
        idle(2 * FR);

        // Set row2 col0, commit mid-frame; visible only after the boundary.
        wait_tick(2 * P);
        step(1'b1, 2, 0, 2'b01, 1'b0, 1'b0, 1'b0);
        wait_tick(4 * P);
        step(1'b0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b1);
        idle(2 * FR);

        // Toggle row5 col15 twice, set col3, commit.
        step(1'b1, 5, 15, 2'b11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5, 15, 2'b11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5, 3, 2'b01, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b1);
        idle(2 * FR);

        // clr_all beats a coincident set of row0 col0.
        step(1'b1, 0, 0, 2'b01, 1'b0, 1'b1, 1'b0);
        step(1'b0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b1);
        idle(2 * FR);

        // Data writes, clear op, then commit + write on the copy edge itself.
        step(1'b1, 3, 7, 2'b00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3, 8, 2'b00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3, 7, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1, 1, 2'b01, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1, 1, 2'b10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1, 2, 2'b01, 1'b0, 1'b0, 1'b0);
        wait_tick(FR - 1);
        step(1'b1, 6, 6, 2'b01, 1'b0, 1'b0, 1'b1);
        idle(2 * FR);

        // Commit arriving on the copy edge while idle: deferred one frame.
        step(1'b1, 7, 0, 2'b01, 1'b0, 1'b0, 1'b0);
        wait_tick(FR - 1);
        step(1'b0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b1);
        idle(2 * FR);

        // Mid-frame reset with a commit pending.
        step(1'b1, 0, 5, 2'b01, 1'b0, 1'b0, 1'b1);
        idle(2 * FR);
        step(1'b1, 0, 9, 2'b01, 1'b0, 1'b0, 1'b1);
        wait_tick(4 * P);
        idle(1);
        reset = 1'b0;
        #1;
        chk_blank("midrst");
        @(posedge div_clk_10k); #1;
        chk_blank("midrst hold");
        reset = 1'b1;
        model_reset();
        idle(FR + 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
